// File: rtl/idu_pkg.sv
// idu_pkg: shared constants for the decode-stage register scoreboard.
//   BYP_SEL_* : bypass select encoding (0 = RF read port, k = post-issue stage k)
//   DEF_*     : default pipeline depth and ready ages
package idu_pkg;

  localparam int BYP_SEL_RF  = 0;
  localparam int BYP_SEL_IEX = 1;
  localparam int BYP_SEL_LSU = 2;
  localparam int BYP_SEL_WB  = 3;

  localparam int DEF_PIPE_DEPTH     = BYP_SEL_WB;
  localparam int DEF_ALU_READY_AGE  = BYP_SEL_IEX;
  localparam int DEF_LOAD_READY_AGE = BYP_SEL_WB;

  // Margin between a load result and an ALU result; used only to keep the
  // encoding self-consistent (LSU sits between IEX and WB).
  localparam int LSU_MINUS_IEX = BYP_SEL_LSU - BYP_SEL_IEX;

endpackage

// File: rtl/idu_scoreboard_lookup.sv
// idu_scoreboard_lookup: resolves one source operand against the scoreboard.
//   src_vld/src_idx : source operand in use / register index
//   busy/age/is_load: registered scoreboard state, one entry per register
//   hazard          : operand not yet bypassable, slot must stall
//   sel             : bypass select (RF when idle or when hazard is raised)
module idu_scoreboard_lookup
  import idu_pkg::*;
#(
  parameter int RF_DEPTH_BIT   = 5,
  parameter int NREG           = 2**RF_DEPTH_BIT,
  parameter int SEL_W          = 2,
  parameter int ALU_READY_AGE  = DEF_ALU_READY_AGE,
  parameter int LOAD_READY_AGE = DEF_LOAD_READY_AGE
) (
  input  logic                             src_vld,
  input  logic [RF_DEPTH_BIT-1:0]          src_idx,
  input  logic [NREG-1:0]                  busy,
  input  logic [NREG-1:0][SEL_W-1:0]       age,
  input  logic [NREG-1:0]                  is_load,
  output logic                             hazard,
  output logic [SEL_W-1:0]                 sel
);

  localparam logic [SEL_W-1:0] ALU_RA = SEL_W'(ALU_READY_AGE);
  localparam logic [SEL_W-1:0] LD_RA  = SEL_W'(LOAD_READY_AGE);

  always_comb begin
    hazard = 1'b0;
    sel    = SEL_W'(BYP_SEL_RF);
    if (src_vld && (src_idx != '0) && busy[src_idx]) begin
      if (age[src_idx] >= (is_load[src_idx] ? LD_RA : ALU_RA))
        sel = age[src_idx];
      else
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/idu_scoreboard.sv
// idu_scoreboard: tracks pending destination registers with a pipeline age and
// produces per-slot bypass selects and in-order stall decisions.
//   clk, rst                       : clock, synchronous active-high reset
//   iss_vld/rd_vld/is_load/rd      : per-slot decode info (slot 0 oldest)
//   iss_rs1*/iss_rs2*              : per-slot source operands
//   flush_vld, pipe_hold           : redirect / backpressure (no acceptance)
//   iss_stall, iss_accept          : per-slot issue decision
//   rs1_byp_sel, rs2_byp_sel       : per-slot bypass selects
//   busy_vec, sb_empty             : pending-register view
module idu_scoreboard
  import idu_pkg::*;
#(
  parameter int ISSUE_NUM      = 2,
  parameter int RF_DEPTH_BIT   = 5,
  parameter int PIPE_DEPTH     = DEF_PIPE_DEPTH,
  parameter int ALU_READY_AGE  = DEF_ALU_READY_AGE,
  parameter int LOAD_READY_AGE = DEF_LOAD_READY_AGE,
  parameter int SEL_W          = $clog2(PIPE_DEPTH+1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ISSUE_NUM-1:0]              iss_vld,
  input  logic [ISSUE_NUM-1:0]              iss_rd_vld,
  input  logic [ISSUE_NUM-1:0]              iss_is_load,
  input  logic [ISSUE_NUM*RF_DEPTH_BIT-1:0] iss_rd,
  input  logic [ISSUE_NUM-1:0]              iss_rs1_vld,
  input  logic [ISSUE_NUM-1:0]              iss_rs2_vld,
  input  logic [ISSUE_NUM*RF_DEPTH_BIT-1:0] iss_rs1,
  input  logic [ISSUE_NUM*RF_DEPTH_BIT-1:0] iss_rs2,
  input  logic                              flush_vld,
  input  logic                              pipe_hold,
  output logic [ISSUE_NUM-1:0]              iss_stall,
  output logic [ISSUE_NUM-1:0]              iss_accept,
  output logic [ISSUE_NUM*SEL_W-1:0]        rs1_byp_sel,
  output logic [ISSUE_NUM*SEL_W-1:0]        rs2_byp_sel,
  output logic [2**RF_DEPTH_BIT-1:0]        busy_vec,
  output logic                              sb_empty
);

  localparam int NREG = 2**RF_DEPTH_BIT;
  localparam logic [SEL_W-1:0] LAST_AGE = SEL_W'(PIPE_DEPTH);

  logic [ISSUE_NUM-1:0][RF_DEPTH_BIT-1:0] rd_a, rs1_a, rs2_a;
  logic [ISSUE_NUM-1:0][SEL_W-1:0]        rs1_sel, rs2_sel;
  logic [ISSUE_NUM-1:0]                   rs1_haz, rs2_haz, haz;

  logic [NREG-1:0]             busy_q, busy_d;
  logic [NREG-1:0][SEL_W-1:0]  age_q, age_d;
  logic [NREG-1:0]             load_q, load_d;

  assign rd_a  = iss_rd;
  assign rs1_a = iss_rs1;
  assign rs2_a = iss_rs2;

  assign rs1_byp_sel = rs1_sel;
  assign rs2_byp_sel = rs2_sel;
  assign busy_vec    = busy_q;
  assign sb_empty    = ~|busy_q;

  // Register-state lookups, one per source operand per slot.
  for (genvar g = 0; g < ISSUE_NUM; g++) begin : g_slot
    idu_scoreboard_lookup #(
      .RF_DEPTH_BIT(RF_DEPTH_BIT), .NREG(NREG), .SEL_W(SEL_W),
      .ALU_READY_AGE(ALU_READY_AGE), .LOAD_READY_AGE(LOAD_READY_AGE)
    ) u_rs1 (
      .src_vld(iss_rs1_vld[g]), .src_idx(rs1_a[g]),
      .busy(busy_q), .age(age_q), .is_load(load_q),
      .hazard(rs1_haz[g]), .sel(rs1_sel[g])
    );
    idu_scoreboard_lookup #(
      .RF_DEPTH_BIT(RF_DEPTH_BIT), .NREG(NREG), .SEL_W(SEL_W),
      .ALU_READY_AGE(ALU_READY_AGE), .LOAD_READY_AGE(LOAD_READY_AGE)
    ) u_rs2 (
      .src_vld(iss_rs2_vld[g]), .src_idx(rs2_a[g]),
      .busy(busy_q), .age(age_q), .is_load(load_q),
      .hazard(rs2_haz[g]), .sel(rs2_sel[g])
    );
  end

  // Hazards (scoreboard + intra-group RAW) and the in-order stall chain.
  // An older stall propagates through every younger slot, valid or not.
  always_comb begin
    logic raw;
    logic chain;
    haz   = '0;
    chain = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      raw = 1'b0;
      for (int i = 0; i < j; i++) begin
        if (iss_vld[i] && iss_rd_vld[i] && (rd_a[i] != '0)) begin
          if (iss_rs1_vld[j] && (rs1_a[j] == rd_a[i])) raw = 1'b1;
          if (iss_rs2_vld[j] && (rs2_a[j] == rd_a[i])) raw = 1'b1;
        end
      end
      haz[j]       = iss_vld[j] & (rs1_haz[j] | rs2_haz[j] | raw);
      chain        = chain | haz[j];
      iss_stall[j] = chain;
    end
  end

  assign iss_accept = iss_vld & ~iss_stall
                    & {ISSUE_NUM{~(flush_vld | pipe_hold | rst)}};

  // Next state: age every pending entry (frozen under hold), retire at the
  // last stage, then allocate accepted writers. Walking slots oldest to
  // youngest lets the youngest writer of a register win, and allocation
  // overrides same-cycle aging/retirement.
  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    load_d = load_q;
    if (!pipe_hold) begin
      for (int r = 1; r < NREG; r++) begin
        if (busy_q[r]) begin
          if (age_q[r] == LAST_AGE) begin
            busy_d[r] = 1'b0;
            age_d[r]  = '0;
            load_d[r] = 1'b0;
          end else begin
            age_d[r] = age_q[r] + 1'b1;
          end
        end
      end
    end
    for (int s = 0; s < ISSUE_NUM; s++) begin
      if (iss_accept[s] && iss_rd_vld[s] && (rd_a[s] != '0)) begin
        busy_d[rd_a[s]] = 1'b1;
        age_d[rd_a[s]]  = SEL_W'(1);
        load_d[rd_a[s]] = iss_is_load[s];
      end
    end
    busy_d[0] = 1'b0;
    age_d[0]  = '0;
    load_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      age_q  <= '0;
      load_q <= '0;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      load_q <= load_d;
    end
  end

endmodule
